// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state encoding and coin denomination constants for the change dispenser.
package vend_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, DONE, ERROR} vend_state_e;
    localparam logic [3:0] COIN_5 = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;
endpackage

// File: rtl/vend_change_dispenser_if.sv
// vend_change_dispenser_if: request, hopper and status signals of the change dispenser.
interface vend_change_dispenser_if #(parameter int AMT_W = 6);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             empty_10;
    logic             empty_5;
    logic             coin_valid;
    logic [3:0]       coin_value;
    logic             coin_ack;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] change_left;
    modport master (
        output req_valid, req_amount, empty_10, empty_5, coin_ack,
        input  req_ready, coin_valid, coin_value, done, err, change_left
    );
    modport slave (
        input  req_valid, req_amount, empty_10, empty_5, coin_ack,
        output req_ready, coin_valid, coin_value, done, err, change_left
    );
endinterface

// File: rtl/vend_ack_timer.sv
// vend_ack_timer: counts cycles spent waiting for coin_ack; expired flags the last allowed cycle.
module vend_ack_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = run ? cnt_q + CW'(1) : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign expired = run && cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: pays out change in 10c/5c coins, preferring 10s and substituting 5s.
// Define VEND_DISPENSE_TIMEOUT_EN to abort a dispense when coin_ack never arrives.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    vend_change_dispenser_if.slave bus
);
    vend_state_e      state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             coin_valid_q, coin_valid_d;
    logic [3:0]       coin_value_q, coin_value_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             req_ready_q, req_ready_d;
    logic             timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef VEND_DISPENSE_TIMEOUT_EN
    vend_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ack_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == DISPENSE),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_value_d = coin_value_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        req_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    remaining_d = bus.req_amount;
                    state_d     = SELECT;
                    req_ready_d = 1'b0;
                end
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (remaining_q >= AMT_W'(2) && !bus.empty_10) begin
                    coin_value_d = COIN_10;
                    coin_valid_d = 1'b1;
                    state_d      = DISPENSE;
                end else if (!bus.empty_5) begin
                    coin_value_d = COIN_5;
                    coin_valid_d = 1'b1;
                    state_d      = DISPENSE;
                end else begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
            DISPENSE: begin
                // An ack outranks a simultaneous timeout: the coin did leave the hopper.
                if (bus.coin_ack && coin_valid_q) begin
                    remaining_d  = remaining_q - (coin_value_q == COIN_10 ? AMT_W'(2) : AMT_W'(1));
                    coin_valid_d = 1'b0;
                    state_d      = SELECT;
                end else if (timeout) begin
                    coin_valid_d = 1'b0;
                    state_d      = ERROR;
                    err_d        = 1'b1;
                end
            end
            DONE, ERROR: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_valid_q <= 1'b0;
            coin_value_q <= 4'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_value_q <= coin_value_d;
            done_q       <= done_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
        end

    assign bus.req_ready   = req_ready_q;
    assign bus.coin_valid  = coin_valid_q;
    assign bus.coin_value  = coin_value_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.change_left = remaining_q;
endmodule
